pwm_deadtime: RTL and testbench
===============================

// Module: pwm_deadtime
// PURPOSE
//  Downstream stage of the tim PWM timer. Takes the timer's raw PWM (out_p_1) and drives a
//  complementary half-bridge pair (out_p/out_n), inserting programmable dead time on each edge.
//  Adds an enable and a latched break (emergency-off) input, and guarantees the pair is never
//  high together. Sits between tim and the gate-driver pins.
// PARAMETERS
//  DT_W   8  width of dead-time counts dt_rise/dt_fall (max dead time 2**DT_W-1 clk cycles)
// PORTS
//  clk       in   1     system clock, all logic on posedge
//  rst       in   1     reset, asynchronous, active-high
//  en        in   1     output enable; 0 = both outputs low
//  dt_rise   in   DT_W  clks from out_n falling to out_p rising
//  dt_fall   in   DT_W  clks from out_p falling to out_n rising
//  pwm_in    in   1     raw PWM from tim (clk domain, no sync needed)
//  brk       in   1     asynchronous break pin, active-high
//  brk_clr   in   1     single-cycle pulse, clears the latched break
//  out_p     out  1     high-side gate drive, registered
//  out_n     out  1     low-side gate drive, registered
//  brk_flag  out  1     latched break status
//  busy      out  1     1 while a dead-time interval is counting
// BEHAVIOUR
//  - Reset: state IDLE, out_p=0, out_n=0, brk_flag=0, busy=0, counter=0, pwm_q=0.
//  - pwm_in registered into pwm_q each clk; FSM acts on pwm_q. brk passes a 2-FF sync (brk_s).
//  - States: IDLE, DT_P (counting toward P_ON), P_ON, DT_N (counting toward N_ON), N_ON, BREAK.
//  - Priority per cycle: brk_s > !en > edge of pwm_q > counter expiry.
//  - IDLE: outputs 0. Leaves when en=1 and brk_flag=0: pwm_q=1 -> DT_P, else -> DT_N.
//  - Enter DT_P: out_p=0,out_n=0, counter loaded with dt_rise (sampled once on entry; later
//    changes of dt_rise do not affect the running interval). Counter decrements per clk;
//    load value 0 or reaching 0 -> P_ON next edge. Thus out_p rises exactly dt_rise clks after
//    the edge at which out_n fell; dt_rise=0 -> out_n falls and out_p rises on the same edge.
//  - DT_N mirrors DT_P with dt_fall, ending in N_ON (out_n=1).
//  - Latency: first edge with pwm_q changed -> outputs off on the next edge (1 clk after pwm_q,
//    2 clk after pwm_in).
//  - pwm_q falls while in DT_P (pulse narrower than dead time): -> DT_N, reload dt_fall; the
//    pulse is swallowed, out_p never asserts. Symmetric for pwm_q rising in DT_N.
//  - pwm_q=1 in P_ON / pwm_q=0 in N_ON: hold. Opposite level -> DT_N / DT_P respectively.
//  - en=0 in any non-BREAK state: IDLE at next edge, outputs 0, counter cleared. Re-enable always
//    passes a full dead-time interval before any output asserts.
//  - brk_s=1: BREAK and brk_flag=1 at next edge, outputs 0, from every state incl. mid-count.
//    BREAK exits to IDLE only on a cycle with brk_clr=1 and brk_s=0; brk_clr while brk_s=1 is
//    ignored. brk_flag clears on that exit edge.
//  - busy = 1 exactly in DT_P/DT_N. Invariant: never out_p=1 and out_n=1 on any cycle.
//  - Counter is DT_W bits, never wraps (no decrement below 0).
// STRUCTURE
//  - pwm_pkg: typedef enum logic [2:0] dt_state_e {IDLE, DT_P, P_ON, DT_N, N_ON, BREAK};
//    localparam DT_W_DEFAULT = 8. Shared with tim and later PWM-channel blocks.
//  - Sub-module: sync_2ff (2-flop synchroniser, reset to 0) for brk. FSM, counter, and output
//    registers stay in pwm_deadtime.
// TESTING  (tim with prescaler=3, counter_period=4 drives pwm_in where noted)
//  1 Reset mid-run: assert rst while P_ON -> out_p/out_n/brk_flag/busy 0 immediately (async).
//  2 dt_rise=3, dt_fall=2, pwm_in step 0->1 after N_ON -> out_n falls 2 clk after step,
//    out_p rises 3 clk later; on 1->0, out_p falls, out_n rises 2 clk later; busy matches.
//  3 dt_rise=dt_fall=0 -> out_p=~out_n, switching on the same edge, 2 clk behind pwm_in.
//  4 dt_rise=5, 2-clk pwm_in high pulse -> out_p stays 0, FSM goes DT_P->DT_N->N_ON.
//  5 brk pulse of 1 clk during DT_P with dt_rise=10 -> outputs 0, brk_flag=1 by 3rd edge;
//    brk_clr while brk=1 ignored; brk_clr after brk=0 -> IDLE, then DT interval before output.
//  6 en toggled 1->0->1 while tim runs -> both 0 next edge; on re-enable full dead time precedes
//    first assertion; assertion checks out_p&out_n==0 on every cycle of every test.

Source files
------------

// File: rtl/pwm_pkg.sv
// pwm_pkg: shared state encoding and defaults for the PWM timer family
package pwm_pkg;
    typedef enum logic [2:0] {IDLE, DT_P, P_ON, DT_N, N_ON, BREAK} dt_state_e;
    localparam int DT_W_DEFAULT = 8;
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchroniser for a single asynchronous input, resets to 0
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic m;
    always_ff @(posedge clk or posedge rst)
        if (rst) {q, m} <= 2'b00;
        else     {q, m} <= {m, d};
endmodule

// File: rtl/pwm_deadtime.sv
// pwm_deadtime: complementary half-bridge driver with programmable dead time and latched break
module pwm_deadtime
    import pwm_pkg::*;
#(
    parameter int DT_W = DT_W_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic [DT_W-1:0] dt_rise,
    input  logic [DT_W-1:0] dt_fall,
    input  logic            pwm_in,
    input  logic            brk,
    input  logic            brk_clr,
    output logic            out_p,
    output logic            out_n,
    output logic            brk_flag,
    output logic            busy
);
    dt_state_e       state, nxt;
    logic [DT_W-1:0] cnt, cnt_nxt;
    logic            pwm_q, brk_s, go;
    sync_2ff u_brk_sync (.clk(clk), .rst(rst), .d(brk), .q(brk_s));
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            pwm_q    <= 1'b0;
            out_p    <= 1'b0;
            out_n    <= 1'b0;
            brk_flag <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state    <= nxt;
            cnt      <= cnt_nxt;
            pwm_q    <= pwm_in;
            out_p    <= nxt == P_ON;
            out_n    <= nxt == N_ON;
            brk_flag <= nxt == BREAK;
            busy     <= nxt == DT_P || nxt == DT_N;
        end
    // go: start a fresh dead-time toward the side pwm_q now asks for
    always_comb begin
        nxt     = state;
        cnt_nxt = '0;
        go      = state == IDLE ||
                  (pwm_q ? (state == DT_N || state == N_ON) : (state == DT_P || state == P_ON));
        if (brk_s)
            nxt = BREAK;
        else if (state == BREAK)
            nxt = brk_clr ? IDLE : BREAK;
        else if (!en)
            nxt = IDLE;
        else if (go) begin
            cnt_nxt = pwm_q ? dt_rise : dt_fall;
            nxt     = pwm_q ? (dt_rise == '0 ? P_ON : DT_P) : (dt_fall == '0 ? N_ON : DT_N);
        end else if (state == DT_P || state == DT_N) begin
            // a count of 1 means this edge completes the interval
            cnt_nxt = |cnt[DT_W-1:1] ? cnt - 1'b1 : '0;
            nxt     = |cnt[DT_W-1:1] ? state : (state == DT_P ? P_ON : N_ON);
        end
    end
endmodule

// File: tb/tb_pwm_deadtime.sv
// tb_pwm_deadtime: directed + randomized checks of pwm_deadtime against a timing model
module tb_pwm_deadtime;
    logic       clk = 1'b0;
    logic       rst, en, pwm_in, brk, brk_clr;
    logic [7:0] dt_rise, dt_fall;
    logic       out_p, out_n, brk_flag, busy;
    int         n_vec = 0, n_err = 0, ph = 0;
    // model: act = driving a side, rem = dead-time clocks still to wait before that side turns on
    bit         m_act, m_side, m_brk, m_pq, m_b1, m_b2;
    int         m_rem;
    pwm_deadtime #(.DT_W(8)) dut (
        .clk(clk), .rst(rst), .en(en), .dt_rise(dt_rise), .dt_fall(dt_fall),
        .pwm_in(pwm_in), .brk(brk), .brk_clr(brk_clr),
        .out_p(out_p), .out_n(out_n), .brk_flag(brk_flag), .busy(busy)
    );
    always #5 clk = ~clk;
    task automatic model_reset();
        m_act = 0; m_side = 0; m_brk = 0; m_pq = 0; m_b1 = 0; m_b2 = 0; m_rem = 0;
    endtask
    task automatic model_edge();
        bit bs = m_b2;
        bit pq = m_pq;
        if (bs) begin
            m_brk = 1; m_act = 0; m_rem = 0;
        end else if (m_brk) begin
            if (brk_clr) m_brk = 0;
        end else if (!en) begin
            m_act = 0; m_rem = 0;
        end else if (!m_act || pq != m_side) begin
            m_act = 1; m_side = pq; m_rem = pq ? int'(dt_rise) : int'(dt_fall);
        end else if (m_rem > 0)
            m_rem--;
        m_b2 = m_b1; m_b1 = brk; m_pq = pwm_in;
    endtask
    task automatic check();
        logic ep, en_, eb, ef;
        ep  = m_act && m_side && m_rem == 0;
        en_ = m_act && !m_side && m_rem == 0;
        eb  = m_act && m_rem > 0;
        ef  = m_brk;
        n_vec += 5;
        assert (out_p === ep) else begin n_err++; $error("FAIL out_p @%0t: got %b expected %b", $time, out_p, ep); end
        assert (out_n === en_) else begin n_err++; $error("FAIL out_n @%0t: got %b expected %b", $time, out_n, en_); end
        assert (busy === eb) else begin n_err++; $error("FAIL busy @%0t: got %b expected %b", $time, busy, eb); end
        assert (brk_flag === ef) else begin n_err++; $error("FAIL brk_flag @%0t: got %b expected %b", $time, brk_flag, ef); end
        assert ((out_p & out_n) === 1'b0) else begin n_err++; $error("FAIL overlap @%0t: got %b expected 0", $time, out_p & out_n); end
    endtask
    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            model_edge();
            #1;
            check();
        end
    endtask
    // tim-like source: 20-clk period, 8 clk high
    task automatic run_tim(input int n);
        for (int i = 0; i < n; i++) begin
            pwm_in = (ph % 20) < 8;
            ph++;
            tick();
        end
    endtask
    initial begin
        rst = 1; en = 0; pwm_in = 0; brk = 0; brk_clr = 0; dt_rise = 0; dt_fall = 0;
        model_reset();
        repeat (2) @(negedge clk);
        check();
        rst = 0;
        // dead-time on both edges
        en = 1; dt_rise = 3; dt_fall = 2;
        tick(8);
        pwm_in = 1; tick(10);
        pwm_in = 0; tick(10);
        // reset asserted mid P_ON acts without a clock edge
        dt_rise = 1; pwm_in = 1; tick(6);
        @(negedge clk);
        rst = 1; #1;
        model_reset();
        check();
        @(negedge clk);
        rst = 0;
        // zero dead time: pure complementary
        dt_rise = 0; dt_fall = 0;
        for (int i = 0; i < 6; i++) begin
            pwm_in = ~pwm_in; tick(3);
        end
        // pulse narrower than dead time is swallowed
        dt_rise = 5; dt_fall = 2; pwm_in = 0; tick(6);
        pwm_in = 1; tick(2);
        pwm_in = 0; tick(10);
        // break during a long DT_P, ignored clear, proper clear
        dt_rise = 10; pwm_in = 1; tick(4);
        brk = 1; tick();
        brk = 0; tick(4);
        brk = 1; tick(3);
        brk_clr = 1; tick();
        brk_clr = 0; tick(2);
        brk = 0; tick(3);
        brk_clr = 1; tick();
        brk_clr = 0; tick(16);
        // enable toggled while the timer runs
        dt_rise = 3; dt_fall = 2;
        run_tim(45);
        en = 0; run_tim(3);
        en = 1; run_tim(45);
        // longest dead time
        dt_rise = 8'hff; pwm_in = 0; tick(5);
        pwm_in = 1; tick(260);
        // randomized traffic
        dt_rise = 2; dt_fall = 1;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 5) == 0) pwm_in = ~pwm_in;
            en      = $urandom_range(0, 79) != 0;
            brk     = $urandom_range(0, 299) == 0;
            brk_clr = $urandom_range(0, 15) == 0;
            if ($urandom_range(0, 19) == 0) dt_rise = 8'($urandom_range(0, 6));
            if ($urandom_range(0, 19) == 0) dt_fall = 8'($urandom_range(0, 6));
            tick();
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
